// File: rtl/pause_tx_scheduler_if.sv
// PAUSE frame request/ack channel between the scheduler (master) and the TX frame inserter (slave).
// The request and quanta are held stable until a one-cycle ack arrives.
interface pause_tx_scheduler_if;
   logic        pause_req;
   logic [15:0] pause_quanta;
   logic        pause_ack;

   modport master (output pause_req, output pause_quanta, input pause_ack);
   modport slave  (input pause_req, input pause_quanta, output pause_ack);
endinterface

// File: rtl/pause_tx_scheduler.sv
// Decides when the TX path sends 802.3x PAUSE frames (XOFF/refresh/XON) from RX FIFO watermarks and software requests.
// Outputs are registered, 1 enabled cycle after the cause; a request holds until the inserter acks it.
module pause_tx_scheduler #(
   parameter int LVL_W        = 12,
   parameter int QUANTA_TICKS = 64
) (
   input  logic                 tx_clk,
   input  logic                 tx_rstn,
   input  logic                 clk_en,
   input  logic                 pause_en,
   input  logic [15:0]          xoff_quanta,
   input  logic [15:0]          refresh_thr,
   input  logic [LVL_W-1:0]     hi_wm,
   input  logic [LVL_W-1:0]     lo_wm,
   input  logic [LVL_W-1:0]     rx_fifo_lvl,
   input  logic                 sw_xoff,
   input  logic                 sw_xon,
   pause_tx_scheduler_if.master pause_if,
   output logic                 xoff_active,
   output logic                 cfg_err
);

   localparam int TICK_W = (QUANTA_TICKS > 1) ? $clog2(QUANTA_TICKS) : 1;
   localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(QUANTA_TICKS - 1);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      XOFF_REQ = 2'd1,
      HOLD     = 2'd2,
      XON_REQ  = 2'd3
   } state_t;

   state_t              state_q, state_d;
   logic [15:0]         quanta_q, quanta_d;
   logic [15:0]         timer_q, timer_d;
   logic [TICK_W-1:0]   tick_q, tick_d;
   logic                xoff_active_q, xoff_active_d;
   logic                cfg_err_q, cfg_err_d;

   logic                hi_hit;
   logic                lo_hit;
   logic                tick_wrap;
   logic [15:0]         timer_nxt;

   always_comb begin
      state_d       = state_q;
      quanta_d      = quanta_q;
      timer_d       = timer_q;
      tick_d        = tick_q;
      xoff_active_d = xoff_active_q;
      cfg_err_d     = cfg_err_q;

      hi_hit    = !cfg_err_q && (rx_fifo_lvl >= hi_wm);
      lo_hit    = !cfg_err_q && (rx_fifo_lvl < lo_wm);
      tick_wrap = (tick_q == TICK_LAST);
      // Refresh/expiry decisions look at the post-decrement timer so they land on the wrap edge itself.
      timer_nxt = (tick_wrap && (timer_q != 16'd0)) ? (timer_q - 16'd1) : timer_q;

      if (clk_en) begin
         cfg_err_d = (lo_wm >= hi_wm);
         unique case (state_q)
            IDLE: begin
               if (pause_en && (hi_hit || sw_xoff)) begin
                  state_d  = XOFF_REQ;
                  quanta_d = xoff_quanta;
               end
            end
            XOFF_REQ: begin
               if (pause_if.pause_ack) begin
                  if (pause_en) begin
                     state_d       = HOLD;
                     timer_d       = quanta_q;
                     tick_d        = '0;
                     xoff_active_d = 1'b1;
                  end else begin
                     state_d       = IDLE;
                     xoff_active_d = 1'b0;
                  end
               end
            end
            HOLD: begin
               tick_d  = tick_wrap ? '0 : (tick_q + 1'b1);
               timer_d = timer_nxt;
               if (!pause_en) begin
                  state_d       = IDLE;
                  xoff_active_d = 1'b0;
               end else if (lo_hit || sw_xon) begin
                  state_d  = XON_REQ;
                  quanta_d = 16'd0;
               // A zero timer means the pause already lapsed; a zero threshold therefore never refreshes.
               end else if ((timer_nxt != 16'd0) && (timer_nxt <= refresh_thr)) begin
                  state_d  = XOFF_REQ;
                  quanta_d = xoff_quanta;
               end else if (timer_nxt == 16'd0) begin
                  state_d       = IDLE;
                  xoff_active_d = 1'b0;
               end
            end
            XON_REQ: begin
               if (pause_if.pause_ack) begin
                  state_d       = IDLE;
                  xoff_active_d = 1'b0;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge tx_clk) begin
      if (!tx_rstn) begin
         state_q       <= IDLE;
         quanta_q      <= 16'd0;
         timer_q       <= 16'd0;
         tick_q        <= '0;
         xoff_active_q <= 1'b0;
         cfg_err_q     <= 1'b0;
      end else begin
         state_q       <= state_d;
         quanta_q      <= quanta_d;
         timer_q       <= timer_d;
         tick_q        <= tick_d;
         xoff_active_q <= xoff_active_d;
         cfg_err_q     <= cfg_err_d;
      end
   end

   assign pause_if.pause_req    = (state_q == XOFF_REQ) || (state_q == XON_REQ);
   assign pause_if.pause_quanta = quanta_q;
   assign xoff_active           = xoff_active_q;
   assign cfg_err               = cfg_err_q;

endmodule

// File: tb/tb_pause_tx_scheduler.sv
// Scoreboard bench: stimulus queues each expected PAUSE frame (quanta, enabled-cycle of request rise);
// a monitor pops and compares on every rising pause_req.
module tb_pause_tx_scheduler;
   logic        tx_clk = 1'b0;
   logic        tx_rstn, clk_en, pause_en, sw_xoff, sw_xon;
   logic [15:0] xoff_quanta, refresh_thr;
   logic [11:0] hi_wm, lo_wm, rx_fifo_lvl;
   logic        xoff_active, cfg_err;

   pause_tx_scheduler_if pif ();

   pause_tx_scheduler #(.LVL_W(12), .QUANTA_TICKS(64)) dut (
      .tx_clk      (tx_clk),
      .tx_rstn     (tx_rstn),
      .clk_en      (clk_en),
      .pause_en    (pause_en),
      .xoff_quanta (xoff_quanta),
      .refresh_thr (refresh_thr),
      .hi_wm       (hi_wm),
      .lo_wm       (lo_wm),
      .rx_fifo_lvl (rx_fifo_lvl),
      .sw_xoff     (sw_xoff),
      .sw_xon      (sw_xon),
      .pause_if    (pif),
      .xoff_active (xoff_active),
      .cfg_err     (cfg_err)
   );

   always #5 tx_clk = ~tx_clk;

   typedef struct {
      logic [15:0] q;
      int          cyc;
   } exp_t;

   exp_t exp_q[$];
   int   vectors = 0;
   int   errors  = 0;
   int   en_cyc  = 0;
   int   en_mode = 0;   // 0: always enabled, 1: one edge in four, 2: held low

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      vectors++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, req);
      end
   endtask

   always @(posedge tx_clk) if (clk_en) en_cyc <= en_cyc + 1;

   initial begin
      int k = 0;
      clk_en = 1'b1;
      forever begin
         @(negedge tx_clk);
         k++;
         case (en_mode)
            0:       clk_en = 1'b1;
            1:       clk_en = (k % 4 == 0);
            default: clk_en = 1'b0;
         endcase
      end
   end

   // Monitor: every new request must match the head of the expected-frame queue.
   initial begin
      logic        req_prev = 1'b0;
      logic [15:0] cur_q    = 16'd0;
      exp_t        e;
      forever begin
         @(negedge tx_clk);
         if (pif.pause_req && !req_prev) begin
            if (exp_q.size() == 0) begin
               chk("unexpected pause_req", 32'd1, 32'd0);
               cur_q = pif.pause_quanta;
            end else begin
               e     = exp_q.pop_front();
               cur_q = e.q;
               chk("frame quanta", pif.pause_quanta, e.q);
               chk("frame cycle", en_cyc, e.cyc);
            end
         end else if (pif.pause_req && req_prev) begin
            chk("quanta stable", pif.pause_quanta, cur_q);
         end
         req_prev = pif.pause_req;
      end
   end

   initial begin
      #950000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors + 1);
      $fatal(1, "timeout");
   end

   task automatic next_en();
      forever begin
         @(posedge tx_clk);
         if (clk_en) break;
      end
      @(negedge tx_clk);
   endtask

   task automatic expect_frame(input logic [15:0] q, input int cyc);
      exp_t e;
      e.q   = q;
      e.cyc = cyc;
      exp_q.push_back(e);
   endtask

   task automatic wait_req(input int lim, input string nm);
      int n = 0;
      while (!pif.pause_req && n < lim) begin
         next_en();
         n++;
      end
      chk(nm, pif.pause_req, 1'b1);
   endtask

   task automatic do_ack(output int cyc);
      pif.pause_ack = 1'b1;
      next_en();
      pif.pause_ack = 1'b0;
      cyc = en_cyc;
      chk("req low after ack", pif.pause_req, 1'b0);
   endtask

   task automatic idle_cycles(input int n);
      repeat (n) next_en();
   endtask

   // XOFF on high watermark, refresh before expiry, then XON below low watermark.
   task automatic run_xoff_refresh_xon(input logic [15:0] q1, input logic [15:0] q2,
                                       input logic [15:0] thr);
      int ack_cyc;
      xoff_quanta = q1;
      refresh_thr = thr;
      rx_fifo_lvl = 12'd800;
      expect_frame(q1, en_cyc + 1);
      wait_req(10, "xoff req");
      xoff_quanta = q2;
      idle_cycles(5);
      chk("pending quanta held", pif.pause_quanta, q1);
      do_ack(ack_cyc);
      chk("xoff_active after ack", xoff_active, 1'b1);
      rx_fifo_lvl = 12'd900;
      expect_frame(q2, ack_cyc + (q1 - thr) * 64);
      wait_req(20000, "refresh req");
      do_ack(ack_cyc);
      chk("xoff_active after refresh", xoff_active, 1'b1);
      rx_fifo_lvl = 12'd200;
      idle_cycles(3);
      chk("no xon at lo_wm", pif.pause_req, 1'b0);
      rx_fifo_lvl = 12'd100;
      expect_frame(16'd0, en_cyc + 1);
      wait_req(10, "xon req");
      chk("xoff_active during xon", xoff_active, 1'b1);
      do_ack(ack_cyc);
      chk("xoff_active after xon", xoff_active, 1'b0);
      idle_cycles(4);
   endtask

   initial begin
      int ack_cyc;
      tx_rstn = 1'b0; pause_en = 1'b1; sw_xoff = 1'b0; sw_xon = 1'b0;
      xoff_quanta = 16'h0100; refresh_thr = 16'h0010;
      hi_wm = 12'd800; lo_wm = 12'd200; rx_fifo_lvl = 12'd0;
      pif.pause_ack = 1'b0;
      repeat (3) @(negedge tx_clk);
      chk("reset pause_req", pif.pause_req, 1'b0);
      chk("reset pause_quanta", pif.pause_quanta, 16'd0);
      chk("reset xoff_active", xoff_active, 1'b0);
      chk("reset cfg_err", cfg_err, 1'b0);
      tx_rstn = 1'b1;
      idle_cycles(2);

      rx_fifo_lvl = 12'd799;
      idle_cycles(3);
      chk("no xoff below hi_wm", pif.pause_req, 1'b0);

      run_xoff_refresh_xon(16'h0100, 16'h0180, 16'h0010);

      // Expiry with refresh disabled and level between watermarks.
      refresh_thr = 16'h0000;
      xoff_quanta = 16'h0100;
      rx_fifo_lvl = 12'd900;
      expect_frame(16'h0100, en_cyc + 1);
      wait_req(10, "t4 xoff req");
      do_ack(ack_cyc);
      rx_fifo_lvl = 12'd300;
      idle_cycles(16383);
      chk("xoff_active before expiry", xoff_active, 1'b1);
      next_en();
      chk("xoff_active after expiry", xoff_active, 1'b0);
      idle_cycles(4);

      // Software requests and simultaneous events.
      refresh_thr = 16'h0010;
      sw_xoff = 1'b1;
      expect_frame(16'h0100, en_cyc + 1);
      next_en();
      sw_xoff = 1'b0;
      wait_req(10, "sw xoff req");
      do_ack(ack_cyc);
      sw_xoff = 1'b1; sw_xon = 1'b1;
      expect_frame(16'd0, en_cyc + 1);
      next_en();
      sw_xoff = 1'b0; sw_xon = 1'b0;
      wait_req(10, "sw xon wins in hold");
      do_ack(ack_cyc);
      chk("xoff_active after sw xon", xoff_active, 1'b0);
      sw_xoff = 1'b1; sw_xon = 1'b1;
      expect_frame(16'h0100, en_cyc + 1);
      next_en();
      sw_xoff = 1'b0; sw_xon = 1'b0;
      wait_req(10, "sw xoff wins in idle");
      do_ack(ack_cyc);
      chk("hold after idle sw xoff", xoff_active, 1'b1);
      sw_xoff = 1'b1;
      next_en();
      sw_xoff = 1'b0;
      idle_cycles(3);
      pause_en = 1'b0;
      next_en();
      chk("pause_en drop clears xoff", xoff_active, 1'b0);
      pause_en = 1'b1;
      sw_xon = 1'b1;
      next_en();
      sw_xon = 1'b0;
      pif.pause_ack = 1'b1;
      next_en();
      pif.pause_ack = 1'b0;
      idle_cycles(3);
      chk("idle ignores sw_xon and ack", {pif.pause_req, xoff_active}, 2'b00);

      // Inverted watermarks disable automatic triggering.
      lo_wm = 12'd900;
      next_en();
      chk("cfg_err set", cfg_err, 1'b1);
      rx_fifo_lvl = 12'd1000;
      idle_cycles(5);
      chk("no auto xoff on cfg_err", pif.pause_req, 1'b0);
      rx_fifo_lvl = 12'd300;
      lo_wm = 12'd200;
      next_en();
      chk("cfg_err clear", cfg_err, 1'b0);

      // Same sequence at quarter-rate enable, shortened quanta.
      en_mode = 1;
      idle_cycles(2);
      run_xoff_refresh_xon(16'h0020, 16'h0030, 16'h0010);
      en_mode = 0;
      idle_cycles(2);

      // Reset while a request is pending, with clk_en held low.
      xoff_quanta = 16'h0100;
      rx_fifo_lvl = 12'd900;
      expect_frame(16'h0100, en_cyc + 1);
      wait_req(10, "pre-reset xoff req");
      en_mode = 2;
      repeat (2) @(negedge tx_clk);
      tx_rstn = 1'b0;
      @(negedge tx_clk);
      chk("mid reset pause_req", pif.pause_req, 1'b0);
      chk("mid reset pause_quanta", pif.pause_quanta, 16'd0);
      chk("mid reset xoff_active", xoff_active, 1'b0);
      tx_rstn = 1'b1;
      rx_fifo_lvl = 12'd0;
      en_mode = 0;
      idle_cycles(4);

      chk("all frames seen", exp_q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end
endmodule
